// File: rtl/uart_cfg_rx.sv
// 8N1 UART receiver that turns host byte pairs (address, data) into register-write
// strobes, or hands bytes straight through as a stream while the downstream is busy.
module uart_cfg_rx #(
  parameter int SCW     = 12,
  parameter int sym_cnt = 2500,
  parameter int TO_SYMS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  input  logic       rx_busy,
  output logic [7:0] rx_dat,
  output logic [7:0] cfg_addr,
  output logic       cfg_we,
  output logic       rx_stb,
  output logic       rx_err
);

  localparam logic [SCW-1:0] SYM_M1   = SCW'(sym_cnt - 1);
  localparam logic [SCW-1:0] SYM_HALF = SCW'(sym_cnt / 2 - 1);
  localparam logic [SCW-1:0] CNT_ONE  = SCW'(1);
  localparam int             TW       = $clog2(TO_SYMS + 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TO_SYMS - 1);
  localparam logic [TW-1:0]  SYM_ONE  = TW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} bit_state_t;
  typedef enum logic {P_ADDR = 1'b0, P_DATA = 1'b1} parse_state_t;

  logic           rx_meta, rxs, rxs_prev, fall;
  bit_state_t     bit_state, bit_state_n;
  parse_state_t   parse_state, parse_state_n;
  logic [SCW-1:0] cnt, cnt_n, tick, tick_n;
  logic [TW-1:0]  syms, syms_n;
  logic [2:0]     idx, idx_n;
  logic [7:0]     shreg, shreg_n, pend, pend_n;
  logic [7:0]     rx_dat_n, cfg_addr_n;
  logic           cfg_we_n, rx_stb_n, rx_err_n;
  logic           byte_valid, frame_err, to_hit;

  // A break (line held low) cannot retrigger: only a high->low step is a start.
  assign fall = rxs_prev & ~rxs;

  // State register: synchroniser, bit FSM, parser and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      rxs_prev    <= 1'b1;
      bit_state   <= IDLE;
      parse_state <= P_ADDR;
      cnt         <= '0;
      tick        <= '0;
      syms        <= '0;
      idx         <= 3'd0;
      shreg       <= 8'h00;
      pend        <= 8'h00;
      rx_dat      <= 8'h00;
      cfg_addr    <= 8'h00;
      cfg_we      <= 1'b0;
      rx_stb      <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      rx_meta     <= RX;
      rxs         <= rx_meta;
      rxs_prev    <= rxs;
      bit_state   <= bit_state_n;
      parse_state <= parse_state_n;
      cnt         <= cnt_n;
      tick        <= tick_n;
      syms        <= syms_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      pend        <= pend_n;
      rx_dat      <= rx_dat_n;
      cfg_addr    <= cfg_addr_n;
      cfg_we      <= cfg_we_n;
      rx_stb      <= rx_stb_n;
      rx_err      <= rx_err_n;
    end
  end

  // Next-state logic for bit timing, parser, idle timeout and output strobes.
  always_comb begin
    bit_state_n = bit_state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;

    case (bit_state)
      IDLE: begin
        if (fall) begin
          cnt_n       = SYM_HALF;
          bit_state_n = START;
        end else begin
          cnt_n = '0;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
        end else if (!rxs) begin
          cnt_n       = SYM_M1;
          idx_n       = 3'd0;
          bit_state_n = DATA;
        end else begin
          bit_state_n = IDLE;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          shreg_n = {rxs, shreg[7:1]};
          cnt_n   = SYM_M1;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
            bit_state_n = STOP;
          end else begin
            bit_state_n = DATA;
          end
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          byte_valid  = rxs;
          frame_err   = ~rxs;
          bit_state_n = IDLE;
        end
      end
      default: begin
        bit_state_n = IDLE;
      end
    endcase

    // Idle symbol periods only accumulate while an address waits for its data byte.
    to_hit = 1'b0;
    if (parse_state == P_DATA && bit_state == IDLE && !fall) begin
      if (tick == SYM_M1) begin
        tick_n = '0;
        syms_n = syms + SYM_ONE;
        to_hit = (syms == TO_LAST);
      end else begin
        tick_n = tick + CNT_ONE;
        syms_n = syms;
      end
    end else begin
      tick_n = '0;
      syms_n = '0;
    end

    parse_state_n = parse_state;
    pend_n        = pend;
    rx_dat_n      = rx_dat;
    cfg_addr_n    = cfg_addr;
    cfg_we_n      = 1'b0;
    rx_stb_n      = 1'b0;
    rx_err_n      = frame_err;

    if (byte_valid) begin
      if (rx_busy) begin
        rx_dat_n      = shreg;
        rx_stb_n      = 1'b1;
        parse_state_n = P_ADDR;
      end else if (parse_state == P_ADDR) begin
        if (shreg != 8'h00) begin
          pend_n        = shreg;
          parse_state_n = P_DATA;
        end else begin
          parse_state_n = P_ADDR;
        end
      end else begin
        cfg_addr_n    = pend;
        rx_dat_n      = shreg;
        cfg_we_n      = 1'b1;
        parse_state_n = P_ADDR;
      end
    end else if (rx_busy || to_hit) begin
      parse_state_n = P_ADDR;
    end else begin
      parse_state_n = parse_state;
    end
  end

endmodule
